// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier.
//   state_t : controller state encoding (3 bits)
//   clog2   : width helper for the iteration counter
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Minimum bit count able to index 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/signed_mult_ctrl_if.sv
// Handshake and data bundle for signed_mult_ctrl.
//   master : start, a, b driven; busy, done, product, product_signal,
//            state_dbg observed
//   slave  : the multiplier side
// Handshake: start is sampled only while the controller is idle; it is
// ignored otherwise and never queued. busy is high from the cycle after
// acceptance until the cycle before done; done is a one-cycle pulse, and
// product/product_signal hold until the next accepted start.
interface signed_mult_ctrl_if #(
  parameter int N = 64
);
  logic                start;
  logic [N-1:0]        a;
  logic [N-1:0]        b;
  logic                busy;
  logic                done;
  logic [2*N-1:0]      product;
  logic                product_signal;
  mult_pkg::state_t    state_dbg;

  modport master (
    output start, a, b,
    input  busy, done, product, product_signal, state_dbg
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, product_signal, state_dbg
  );
endinterface

// File: rtl/abs_value.sv
// Combinational two's-complement magnitude/sign split.
//   value     : signed N-bit input
//   magnitude : |value| as N-bit unsigned (-2^(N-1) maps to 2^(N-1))
//   sign      : MSB of value
module abs_value #(
  parameter int N = 64
) (
  input  logic [N-1:0] value,
  output logic [N-1:0] magnitude,
  output logic         sign
);
  assign sign      = value[N-1];
  assign magnitude = sign ? (~value + N'(1)) : value;
endmodule

// File: rtl/signed_mult_ctrl.sv
// Sequential signed multiplier: magnitude shift-add over N RUN cycles,
// then the result sign is applied in FIX.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : signed_mult_ctrl_if slave (start/a/b in; busy/done/product/
//           product_signal/state_dbg out)
module signed_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  signed_mult_ctrl_if.slave     bus
);
  localparam int CW = clog2(N);
  localparam int PW = 2 * N;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t         state, state_nxt;
  logic [N-1:0]   a_q, b_q;
  logic [N-1:0]   mag_a, mag_b;
  logic [N-1:0]   abs_a, abs_b;
  logic           sign_a, sign_b;
  logic           res_sign;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  fixed;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  product_q;
  logic           product_signal_q;
  logic           busy_c, done_c;

  abs_value #(.N(N)) u_abs_a (.value(a_q), .magnitude(abs_a), .sign(sign_a));
  abs_value #(.N(N)) u_abs_b (.value(b_q), .magnitude(abs_b), .sign(sign_b));

  // Negating a zero accumulator yields zero, so no negative zero appears.
  assign fixed = res_sign ? (~acc + PW'(1)) : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = PREP;
      PREP: begin
        busy_c    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_LAST) state_nxt = FIX;
      end
      FIX: begin
        busy_c    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q              <= '0;
      b_q              <= '0;
      mag_a            <= '0;
      mag_b            <= '0;
      res_sign         <= 1'b0;
      acc              <= '0;
      cnt              <= '0;
      product_q        <= '0;
      product_signal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
          end
        end
        PREP: begin
          mag_a    <= abs_a;
          mag_b    <= abs_b;
          res_sign <= sign_a ^ sign_b;
          acc      <= '0;
          cnt      <= '0;
        end
        RUN: begin
          // Partial product for bit cnt of |b|; the 2N-bit sum cannot overflow.
          if (mag_b[cnt]) acc <= acc + ({{N{1'b0}}, mag_a} << cnt);
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          product_q        <= fixed;
          product_signal_q <= fixed[PW-1];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.product        = product_q;
  assign bus.product_signal = product_signal_q;
  assign bus.state_dbg      = state;
endmodule

// File: tb/tb_signed_mult_ctrl.sv
module tb_signed_mult_ctrl;
  import mult_pkg::*;

  localparam int N8 = 8;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  signed_mult_ctrl_if #(.N(8))  if8 ();
  signed_mult_ctrl_if #(.N(64)) if64 ();

  signed_mult_ctrl #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  signed_mult_ctrl #(.N(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation with latency, busy-length and result checks.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [15:0] exp_p);
    int   lat;
    int   busy_n;
    logic seen;
    @(negedge clk);
    if8.a = av;
    if8.b = bv;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    lat = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      if (if8.done) seen = 1'b1;
      else begin
        if (if8.busy) busy_n++;
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 128'(seen), 128'(1));
    chk({tag, "_latency"}, 128'(lat), 128'(N8 + 2));
    chk({tag, "_busy_cycles"}, 128'(busy_n), 128'(N8 + 2));
    chk({tag, "_product"}, 128'(if8.product), 128'(exp_p));
    chk({tag, "_sign"}, 128'(if8.product_signal), 128'(exp_p[15]));
    @(posedge clk);
    #1;
    chk({tag, "_done_low"}, 128'(if8.done), 128'(0));
    chk({tag, "_hold"}, 128'(if8.product), 128'(exp_p));
  endtask

  initial begin
    int pulses;
    int e;
    int d1;
    int d2;
    int lat;
    pass_cnt = 0;
    fail_cnt = 0;
    total_cnt = 0;
    if8.start = 1'b0;
    if8.a = '0;
    if8.b = '0;
    if64.start = 1'b0;
    if64.a = '0;
    if64.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(if8.busy), 128'(0));
    chk("rst_done", 128'(if8.done), 128'(0));
    chk("rst_product", 128'(if8.product), 128'(0));
    chk("rst_sign", 128'(if8.product_signal), 128'(0));
    chk("rst_state", 128'(if8.state_dbg), 128'(IDLE));
    chk("rst_product64", if64.product, 128'(0));
    rst_n = 1'b1;

    // directed vectors
    op8("m3x5",      8'hFD, 8'd5,   16'hFFF1);
    op8("m128xm128", 8'h80, 8'h80,  16'h4000);
    op8("m128x127",  8'h80, 8'd127, 16'hC080);
    op8("zero_x_m7", 8'd0,  8'hF9,  16'h0000);
    op8("m1xm1",     8'hFF, 8'hFF,  16'h0001);
    op8("7xm9",      8'd7,  8'hF7,  16'hFFC1);

    // start during RUN is ignored
    @(negedge clk);
    if8.a = 8'd5;
    if8.b = 8'd6;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (if8.done) pulses++;
    end
    if8.a = 8'd7;
    if8.b = 8'd7;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    if8.a = 8'd0;
    if8.b = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (if8.done) pulses++;
    end
    chk("ignore_pulses", 128'(pulses), 128'(1));
    chk("ignore_product", 128'(if8.product), 128'(16'h001E));
    chk("ignore_state", 128'(if8.state_dbg), 128'(IDLE));

    // reset during RUN (cnt = 4)
    @(negedge clk);
    if8.a = 8'd9;
    if8.b = 8'd9;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_busy", 128'(if8.busy), 128'(0));
    chk("midrst_done", 128'(if8.done), 128'(0));
    chk("midrst_product", 128'(if8.product), 128'(0));
    chk("midrst_state", 128'(if8.state_dbg), 128'(IDLE));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (if8.done) pulses++;
    end
    chk("midrst_no_done", 128'(pulses), 128'(0));
    op8("after_rst", 8'd12, 8'hFD, 16'hFFDC);

    // start held high: back-to-back operations every N+4 cycles
    @(negedge clk);
    if8.a = 8'd2;
    if8.b = 8'd3;
    if8.start = 1'b1;
    e = 0;
    d1 = -1;
    d2 = -1;
    while (d2 < 0 && e < 100) begin
      @(posedge clk);
      #1;
      e++;
      if (if8.done) begin
        if (d1 < 0) d1 = e;
        else        d2 = e;
      end
    end
    if8.start = 1'b0;
    chk("held_first_done", 128'(d1), 128'(N8 + 3));
    chk("held_gap", 128'(d2 - d1), 128'(N8 + 4));
    chk("held_product", 128'(if8.product), 128'(16'h0006));

    // N = 64: -2^63 * 3
    @(negedge clk);
    if64.a = 64'h8000_0000_0000_0000;
    if64.b = 64'd3;
    if64.start = 1'b1;
    @(posedge clk);
    #1;
    if64.start = 1'b0;
    lat = 0;
    while (!if64.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("n64_latency", 128'(lat), 128'(66));
    chk("n64_product", if64.product, 128'hFFFF_FFFF_FFFF_FFFE_8000_0000_0000_0000);
    chk("n64_sign", 128'(if64.product_signal), 128'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
